load_store_unit: RTL and testbench

- Sits directly upstream of port B of the dual-port BRAM main memory.
- Turns core load/store requests (byte/half/word, signed/unsigned) into word-aligned memory accesses with byte enables and lane-replicated write data.
- Extracts and sign/zero-extends load data from the memory's 1-cycle registered read.
- Detects misaligned and out-of-range accesses and reports them as faults without touching memory.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/load_store_unit_load_extract.sv | 33 +++
 rtl/load_store_unit.sv | 123 ++++++++++++
 tb/tb_load_store_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and the access-fault check for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    RESP    = 2'b11
  } state_t;

  // Rejects illegal sizes, misaligned halves/words and addresses beyond the memory.
  function automatic logic access_fault(input logic [31:0] addr,
                                        input logic [1:0]  size,
                                        input int          addr_w);
    logic [31:0] high_bits;
    logic        bad_align;
    high_bits = addr >> addr_w;
    case (size)
      SIZE_BYTE: bad_align = 1'b0;
      SIZE_HALF: bad_align = addr[0];
      SIZE_WORD: bad_align = (addr[1:0] != 2'b00);
      default:   bad_align = 1'b1;
    endcase
    access_fault = bad_align || (high_bits != 32'd0);
  endfunction

endpackage

// File: rtl/load_store_unit_load_extract.sv
// Picks the addressed byte/half lane out of a memory word and extends it to 32 bits.
module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] value
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    lane8  = 8'd0;
    lane16 = 16'd0;
    value  = word;
    case (addr)
      2'd0:    lane8 = word[7:0];
      2'd1:    lane8 = word[15:8];
      2'd2:    lane8 = word[23:16];
      default: lane8 = word[31:24];
    endcase
    lane16 = addr[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: value = zero_ext ? {24'd0, lane8} : {{24{lane8[7]}}, lane8};
      SIZE_HALF: value = zero_ext ? {16'd0, lane16} : {{16{lane16[15]}}, lane16};
      default:   value = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Core-to-BRAM load/store unit: one request at a time, byte enables on stores,
// lane extraction on loads, and fault reporting without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 8192,
  parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i,
  output logic [3:0]        mem_data_en,
  output logic              mem_write_en
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              fault_q;
  logic              req_fault;
  logic [31:0]       load_value;
  logic              issue_store;
  logic [3:0]        lane_en;
  logic [31:0]       lane_data;

  assign req_fault = access_fault(req_addr, req_size, ADDR_W);

  load_extract u_load_extract (
    .word     (mem_data_i),
    .addr     (addr_q[1:0]),
    .size     (size_q),
    .zero_ext (uns_q),
    .value    (load_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr[ADDR_W-1:0];
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            rdata_q <= 32'd0;
            fault_q <= req_fault;
            state   <= req_fault ? RESP : ISSUE;
          end
        end
        ISSUE:   state <= we_q ? RESP : CAPTURE;
        // Memory read is registered, so the addressed word is on mem_data_i here.
        CAPTURE: begin
          rdata_q <= load_value;
          state   <= RESP;
        end
        RESP: begin
          rdata_q <= 32'd0;
          fault_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    lane_en   = 4'b0000;
    lane_data = 32'd0;
    case (size_q)
      SIZE_BYTE: begin
        lane_en   = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      SIZE_HALF: begin
        lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
  end

  // rst gates the strobes combinationally so a store caught in ISSUE never writes.
  assign issue_store  = (state == ISSUE) && we_q && !rst;
  assign mem_write_en = issue_store;
  assign mem_data_en  = issue_store ? lane_en : 4'b0000;
  assign mem_data_o   = issue_store ? lane_data : 32'd0;
  assign mem_addr     = ((state == ISSUE) && !rst) ? addr_q : '0;

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP) && !rst;
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_fault = resp_valid ? fault_q : 1'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven, scoreboarded bench for load_store_unit against a behavioural
// model of the BRAM's port B (registered read, byte-enabled write).
module tb_load_store_unit;

  localparam int MEM_SIZE = 8192;
  localparam int ADDR_W   = 13;
  localparam int NVEC     = 22;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
    logic [3:0]  en;
    logic [31:0] data_o;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          acc;
  } sb_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_addr = 32'd0;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data_o;
  logic [31:0]       mem_data_i = 32'd0;
  logic [3:0]        mem_data_en;
  logic              mem_write_en;

  logic [31:0] mem [0:MEM_SIZE/4-1];
  vec_t        vecs [NVEC];
  sb_t         sb [$];
  int          cyc = 0;
  int          assertions = 0;
  int          failures = 0;
  int          resp_count = 0;

  load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_addr     (mem_addr),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_data_en  (mem_data_en),
    .mem_write_en (mem_write_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_write_en)
      for (int b = 0; b < 4; b++)
        if (mem_data_en[b]) mem[mem_addr[12:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
    mem_data_i <= mem[mem_addr[12:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Every response is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    sb_t e;
    if (resp_valid) begin
      resp_count++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("resp_rdata", resp_rdata, e.rdata);
        checkOutput("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
        checkOutput("resp_latency", cyc - e.acc, e.lat);
      end
    end else begin
      checkOutput("idle_rdata", resp_rdata, 32'd0);
      checkOutput("idle_fault", {31'd0, resp_fault}, 32'd0);
    end
  end

  task automatic driveReq(input vec_t v);
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
  endtask

  function automatic sb_t expectOf(input vec_t v, input int acc);
    sb_t e;
    e.rdata = (v.we || v.fault) ? 32'd0 : v.rdata;
    e.fault = v.fault;
    e.lat   = v.fault ? 1 : (v.we ? 2 : 3);
    e.acc   = acc;
    return e;
  endfunction

  // Drives one request at a negedge where req_ready is high; returns just after the accepting edge.
  task automatic applyStimulus(input vec_t v, input bit expect_resp);
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready) begin
        driveReq(v);
        req_valid = 1'b1;
        if (expect_resp) sb.push_back(expectOf(v, cyc));
        got = 1;
      end
    end
    if (!got) checkOutput("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic checkIssue(input vec_t v);
    logic we_exp;
    we_exp = v.we && !v.fault;
    @(negedge clk);
    checkOutput("c1_write_en", {31'd0, mem_write_en}, {31'd0, we_exp});
    checkOutput("c1_data_en", {28'd0, mem_data_en}, we_exp ? {28'd0, v.en} : 32'd0);
    checkOutput("c1_data_o", mem_data_o, we_exp ? v.data_o : 32'd0);
    checkOutput("c1_mem_addr", {19'd0, mem_addr}, v.fault ? 32'd0 : {19'd0, v.addr[12:0]});
    checkOutput("c1_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    checkOutput("c2_write_en", {31'd0, mem_write_en}, 32'd0);
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      checkOutput("resp_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    vec_t v;
    int   accepts;
    int   last_acc;
    int   resp_before;

    for (int i = 0; i < MEM_SIZE/4; i++) mem[i] = 32'd0;

    //               we    size   uns   addr          wdata          rdata          flt   en       data_o
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h123456AA, 32'h0,        1'b0, 4'b1000, 32'hAAAAAAAA};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'hFFFFFFAA, 1'b0, 4'b0000, 32'h0};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h000000AA, 1'b0, 4'b0000, 32'h0};
    vecs[4]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'hFFFF8001, 32'h0,        1'b0, 4'b1100, 32'h80018001};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,        32'hFFFF8001, 1'b0, 4'b0000, 32'h0};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'h8001BEEF, 1'b0, 4'b0000, 32'h0};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,        32'h00008001, 1'b0, 4'b0000, 32'h0};
    vecs[8]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0,        32'hFFFFFFEF, 1'b0, 4'b0000, 32'h0};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0,        32'h000000BE, 1'b0, 4'b0000, 32'h0};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0,        32'hFFFFBEEF, 1'b0, 4'b0000, 32'h0};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'hCAFEF00D, 32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[15] = '{1'b1, 2'b01, 1'b0, 32'h0000_1FFE, 32'h00007F00, 32'h0,        1'b0, 4'b1100, 32'h7F007F00};
    vecs[16] = '{1'b0, 2'b01, 1'b0, 32'h0000_1FFE, 32'h0,        32'h00007F00, 1'b0, 4'b0000, 32'h0};
    vecs[17] = '{1'b1, 2'b00, 1'b0, 32'h0000_1FFC, 32'h00000080, 32'h0,        1'b0, 4'b0001, 32'h80808080};
    vecs[18] = '{1'b0, 2'b00, 1'b0, 32'h0000_1FFC, 32'h0,        32'hFFFFFF80, 1'b0, 4'b0000, 32'h0};
    vecs[19] = '{1'b0, 2'b10, 1'b0, 32'h0000_1FFC, 32'h0,        32'h7F000080, 1'b0, 4'b0000, 32'h0};
    vecs[20] = '{1'b1, 2'b00, 1'b0, 32'h8000_0000, 32'h00000055, 32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[21] = '{1'b0, 2'b00, 1'b1, 32'h0000_1FFF, 32'h0,        32'h0000007F, 1'b0, 4'b0000, 32'h0};

    $display("[TB] reset phase");
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("rst_write_en", {31'd0, mem_write_en}, 32'd0);
      checkOutput("rst_data_en", {28'd0, mem_data_en}, 32'd0);
      checkOutput("rst_mem_addr", {19'd0, mem_addr}, 32'd0);
      checkOutput("rst_data_o", mem_data_o, 32'd0);
    end
    rst = 1'b0;
    #1;
    checkOutput("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("post_rst_write_en", {31'd0, mem_write_en}, 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], 1'b1);
      checkIssue(vecs[i]);
      waitIdle();
    end

    $display("[TB] reset during store issue");
    v = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h12345678, 32'h0, 1'b0, 4'b1111, 32'h12345678};
    applyStimulus(v, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_issue_write_en", {31'd0, mem_write_en}, 32'd0);
    checkOutput("rst_issue_data_en", {28'd0, mem_data_en}, 32'd0);
    resp_before = resp_count;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("rst_dropped_resp", resp_count - resp_before, 32'd0);
    v = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h8001BEEF, 1'b0, 4'b0000, 32'h0};
    applyStimulus(v, 1'b1);
    waitIdle();

    $display("[TB] back-to-back held request");
    resp_before = resp_count;
    accepts  = 0;
    last_acc = 0;
    @(negedge clk);
    driveReq(v);
    req_valid = 1'b1;
    for (int k = 0; k < 40 && accepts < 3; k++) begin
      if (req_ready) begin
        if (accepts > 0) checkOutput("b2b_accept_gap", cyc - last_acc, 32'd4);
        last_acc = cyc;
        sb.push_back(expectOf(v, cyc));
        accepts++;
      end
      if (accepts < 3) @(negedge clk);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    checkOutput("b2b_accepts", accepts, 32'd3);
    waitIdle();
    checkOutput("b2b_resp_count", resp_count - resp_before, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
